resource_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource (e.g. the shared UART TX or bus

---
 rtl/resource_arbiter_pkg.sv | 18 +
 rtl/resource_arbiter_rr_mask_select.sv | 49 ++++
 rtl/resource_arbiter.sv | 105 ++++++++++
 tb/tb_resource_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resource_arbiter_pkg.sv
// ============================================================================
// Module  : resource_arbiter_pkg
// Brief   : Shared state encoding for the round-robin resource arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package resource_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_HOLD = 2'd1,
      ARB_GAP  = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/resource_arbiter_rr_mask_select.sv
// ============================================================================
// Module  : rr_mask_select
// Brief   : Combinational round-robin pick: first request at index >= ptr,
//           wrapping to the lowest request otherwise.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mask_select
   import resource_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ID_W  = 3
) (
   input  logic [WIDTH-1:0] requests,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  winner,
   output logic             valid
);

   logic [ID_W-1:0] w_hi_idx;
   logic [ID_W-1:0] w_lo_idx;
   logic            w_hi_valid;
   logic            w_lo_valid;

   // Scan downward so the lowest qualifying index is the last one written.
   always_comb begin
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      w_hi_valid = 1'b0;
      w_lo_valid = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (requests[i]) begin
            w_lo_idx   = ID_W'(i);
            w_lo_valid = 1'b1;
            if (ID_W'(i) >= ptr) begin
               w_hi_idx   = ID_W'(i);
               w_hi_valid = 1'b1;
            end
         end
      end
   end

   assign winner = w_hi_valid ? w_hi_idx : w_lo_idx;
   assign valid  = w_lo_valid;

endmodule

`default_nettype wire

// File: rtl/resource_arbiter.sv
// ============================================================================
// Module  : resource_arbiter
// Brief   : Round-robin arbiter with grant hold, watchdog revoke and one dead
//           cycle between owners.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module resource_arbiter
   import resource_arbiter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int ID_W    = 3,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] requests,
   output logic [WIDTH-1:0] grants,
   output logic             granted,
   output logic [ID_W-1:0]  grant_id,
   output logic             timeout,
   output logic [ID_W-1:0]  timeout_id
);

   localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
   localparam logic [ID_W-1:0]  c_LAST_ID = ID_W'(WIDTH - 1);
   localparam logic [TO_W-1:0]  c_TO_LAST = TO_W'(TIMEOUT - 1);
   localparam bit               c_WD_EN   = (TIMEOUT != 0);

   arb_state_t       r_state;
   logic [ID_W-1:0]  r_ptr;
   logic [TO_W-1:0]  r_count;
   logic [WIDTH-1:0] r_grants;
   logic [ID_W-1:0]  r_grant_id;
   logic             r_timeout;
   logic [ID_W-1:0]  r_timeout_id;
   logic [ID_W-1:0]  w_winner;
   logic             w_valid;

   rr_mask_select #(
      .WIDTH (WIDTH),
      .ID_W  (ID_W)
   ) u_select (
      .requests (requests),
      .ptr      (r_ptr),
      .winner   (w_winner),
      .valid    (w_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ARB_IDLE;
         r_ptr        <= '0;
         r_count      <= '0;
         r_grants     <= '0;
         r_grant_id   <= '0;
         r_timeout    <= 1'b0;
         r_timeout_id <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ARB_HOLD: begin
               if (r_count != '1) begin
                  r_count <= r_count + TO_W'(1);
               end
               // Release takes priority over a coincident watchdog expiry.
               if (!requests[r_grant_id]) begin
                  r_grants   <= '0;
                  r_grant_id <= '0;
                  r_state    <= ARB_GAP;
               end else if (c_WD_EN && (r_count == c_TO_LAST)) begin
                  r_grants     <= '0;
                  r_grant_id   <= '0;
                  r_timeout    <= 1'b1;
                  r_timeout_id <= r_grant_id;
                  r_state      <= ARB_GAP;
               end
            end
            default: begin
               if (enable && w_valid) begin
                  r_grants   <= c_ONE << w_winner;
                  r_grant_id <= w_winner;
                  r_ptr      <= (w_winner == c_LAST_ID) ? '0 : w_winner + ID_W'(1);
                  r_count    <= '0;
                  r_state    <= ARB_HOLD;
               end else begin
                  r_state <= ARB_IDLE;
               end
            end
         endcase
      end
   end

   assign grants     = r_grants;
   assign granted    = |r_grants;
   assign grant_id   = r_grant_id;
   assign timeout    = r_timeout;
   assign timeout_id = r_timeout_id;

endmodule

`default_nettype wire

// File: tb/tb_resource_arbiter.sv
// ============================================================================
// Module  : tb_resource_arbiter
// Brief   : Scenario and randomized checks of resource_arbiter (WIDTH=4,
//           TIMEOUT=8) against a behavioural owner/pointer model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_resource_arbiter;

   localparam int W  = 4;
   localparam int TO = 8;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [3:0] requests;
   logic [3:0] grants;
   logic       granted;
   logic [1:0] grant_id;
   logic       timeout;
   logic [1:0] timeout_id;
   logic [3:0] nw_grants;
   logic       nw_granted;
   logic [1:0] nw_grant_id;
   logic       nw_timeout;
   logic [1:0] nw_timeout_id;

   int n_checks = 0;
   int n_fail   = 0;

   resource_arbiter #(.WIDTH(W), .ID_W(2), .TO_W(16), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .requests   (requests),
      .grants     (grants),
      .granted    (granted),
      .grant_id   (grant_id),
      .timeout    (timeout),
      .timeout_id (timeout_id)
   );

   resource_arbiter #(.WIDTH(W), .ID_W(2), .TO_W(16), .TIMEOUT(0)) dut_nowd (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .requests   (requests),
      .grants     (nw_grants),
      .granted    (nw_granted),
      .grant_id   (nw_grant_id),
      .timeout    (nw_timeout),
      .timeout_id (nw_timeout_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: who owns the resource, how long, and where rotation resumes.
   int         m_owner = -1;
   int         m_ptr   = 0;
   int         m_held  = 0;
   int         m_cand;
   logic       m_tout  = 1'b0;
   logic [1:0] m_tout_id = 2'd0;
   logic [3:0] m_grants = 4'd0;
   logic [1:0] m_id = 2'd0;

   always @(posedge clk) begin
      if (rst) begin
         m_owner   = -1;
         m_ptr     = 0;
         m_held    = 0;
         m_tout    = 1'b0;
         m_tout_id = 2'd0;
      end else begin
         m_tout = 1'b0;
         if (m_owner >= 0) begin
            m_held = m_held + 1;
            if (!requests[m_owner]) begin
               m_owner = -1;
            end else if (m_held == TO) begin
               m_tout    = 1'b1;
               m_tout_id = m_owner[1:0];
               m_owner   = -1;
            end
         end else if (enable && requests != 4'd0) begin
            for (int k = 0; k < W; k++) begin
               m_cand = (m_ptr + k) % W;
               if (requests[m_cand]) begin
                  m_owner = m_cand;
                  break;
               end
            end
            m_ptr  = (m_owner + 1) % W;
            m_held = 0;
         end
      end
      m_grants = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      m_id     = (m_owner >= 0) ? m_owner[1:0] : 2'd0;
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      requests = 4'hF;
      enable   = 1'b1;
      rst      = 1'b1;
      tick();
      tick();
      n_checks += 5;
      if (grants !== 4'd0)     begin n_fail++; $display("FAIL reset_grants got=%b exp=0000", grants); end
      if (granted !== 1'b0)    begin n_fail++; $display("FAIL reset_granted got=%b exp=0", granted); end
      if (grant_id !== 2'd0)   begin n_fail++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
      if (timeout !== 1'b0)    begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
      if (timeout_id !== 2'd0) begin n_fail++; $display("FAIL reset_timeout_id got=%0d exp=0", timeout_id); end
      rst = 1'b0;
      tick();
      n_checks += 3;
      if (grants !== 4'b0001)  begin n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", grants); end
      if (granted !== 1'b1)    begin n_fail++; $display("FAIL reset_first_granted got=%b exp=1", granted); end
      if (grants !== m_grants) begin n_fail++; $display("FAIL reset_model got=%b exp=%b", grants, m_grants); end
   endtask

   task automatic test_rotation;
      int         exp;
      logic [3:0] exp_vec;
      requests = 4'hF;
      enable   = 1'b1;
      do_reset();
      for (int g = 0; g < 5; g++) begin
         exp     = g % W;
         exp_vec = 4'b0001 << exp;
         tick();
         n_checks += 2;
         if (grants !== exp_vec || grant_id !== exp[1:0]) begin
            n_fail++; $display("FAIL rotation_grant[%0d] got=%b/%0d exp=%b/%0d", g, grants, grant_id, exp_vec, exp);
         end
         if (grants !== m_grants) begin n_fail++; $display("FAIL rotation_model[%0d] got=%b exp=%b", g, grants, m_grants); end
         tick();
         tick();
         n_checks++;
         if (grants !== exp_vec) begin n_fail++; $display("FAIL rotation_hold[%0d] got=%b exp=%b", g, grants, exp_vec); end
         requests[exp] = 1'b0;
         tick();
         n_checks++;
         if (grants !== 4'd0 || granted !== 1'b0 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL rotation_gap[%0d] got=%b/%b/%0d exp=0000/0/0", g, grants, granted, grant_id);
         end
         requests[exp] = 1'b1;
      end
   endtask

   task automatic test_wrap_skip;
      requests = 4'b0000;
      enable   = 1'b1;
      do_reset();
      requests = 4'b0100;
      tick();
      requests = 4'b0000;
      tick();
      tick();
      requests = 4'b0101;
      tick();
      n_checks += 2;
      if (grants !== 4'b0001)  begin n_fail++; $display("FAIL wrap_first got=%b exp=0001", grants); end
      if (grants !== m_grants) begin n_fail++; $display("FAIL wrap_model got=%b exp=%b", grants, m_grants); end
      requests = 4'b0100;
      tick();
      n_checks++;
      if (grants !== 4'd0) begin n_fail++; $display("FAIL wrap_gap got=%b exp=0000", grants); end
      tick();
      n_checks += 2;
      if (grants !== 4'b0100 || grant_id !== 2'd2) begin
         n_fail++; $display("FAIL wrap_second got=%b/%0d exp=0100/2", grants, grant_id);
      end
      if (grants !== m_grants) begin n_fail++; $display("FAIL wrap_model2 got=%b exp=%b", grants, m_grants); end
      requests = 4'b0000;
      tick();
   endtask

   task automatic test_watchdog;
      int n_held;
      requests = 4'b0000;
      enable   = 1'b1;
      do_reset();
      requests = 4'b0010;
      tick();
      n_held = (grants === 4'b0010) ? 1 : 0;
      for (int i = 0; i < 20 && n_held > 0; i++) begin
         tick();
         if (grants === 4'b0010) n_held++;
         else break;
      end
      n_checks += 4;
      if (n_held != TO)        begin n_fail++; $display("FAIL wd_hold_cycles got=%0d exp=%0d", n_held, TO); end
      if (timeout !== 1'b1)    begin n_fail++; $display("FAIL wd_pulse got=%b exp=1", timeout); end
      if (timeout_id !== 2'd1) begin n_fail++; $display("FAIL wd_id got=%0d exp=1", timeout_id); end
      if (grants !== 4'd0)     begin n_fail++; $display("FAIL wd_gap got=%b exp=0000", grants); end
      tick();
      n_checks += 3;
      if (timeout !== 1'b0)    begin n_fail++; $display("FAIL wd_pulse_end got=%b exp=0", timeout); end
      if (grants !== 4'b0010)  begin n_fail++; $display("FAIL wd_regrant got=%b exp=0010", grants); end
      if (timeout_id !== 2'd1) begin n_fail++; $display("FAIL wd_id_held got=%0d exp=1", timeout_id); end
      requests = 4'b0000;
      tick();
   endtask

   task automatic test_release_vs_timeout;
      int bad;
      requests = 4'b0000;
      enable   = 1'b1;
      do_reset();
      requests = 4'b0001;
      tick();
      repeat (TO - 1) tick();
      n_checks++;
      if (grants !== 4'b0001) begin n_fail++; $display("FAIL rvt_held8 got=%b exp=0001", grants); end
      requests = 4'b0000;
      tick();
      n_checks += 2;
      if (grants !== 4'd0)  begin n_fail++; $display("FAIL rvt_release got=%b exp=0000", grants); end
      if (timeout !== 1'b0) begin n_fail++; $display("FAIL rvt_no_pulse got=%b exp=0", timeout); end
      do_reset();
      requests = 4'b0001;
      tick();
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         n_checks++;
         if (nw_grants !== 4'b0001 || nw_timeout !== 1'b0) begin
            n_fail++;
            if (bad < 3) $display("FAIL nowd_hold[%0d] got=%b/%b exp=0001/0", i, nw_grants, nw_timeout);
            bad++;
         end
      end
      requests = 4'b0000;
      tick();
   endtask

   task automatic test_enable_reset;
      requests = 4'b0000;
      enable   = 1'b1;
      do_reset();
      requests = 4'b0100;
      tick();
      enable = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (grants !== 4'b0100) begin n_fail++; $display("FAIL en_hold got=%b exp=0100", grants); end
      requests = 4'b1000;
      repeat (4) tick();
      n_checks++;
      if (grants !== 4'd0) begin n_fail++; $display("FAIL en_blocked got=%b exp=0000", grants); end
      enable = 1'b1;
      tick();
      n_checks += 2;
      if (grants !== 4'b1000 || grant_id !== 2'd3) begin
         n_fail++; $display("FAIL en_resume got=%b/%0d exp=1000/3", grants, grant_id);
      end
      if (grants !== m_grants) begin n_fail++; $display("FAIL en_model got=%b exp=%b", grants, m_grants); end
      rst = 1'b1;
      tick();
      n_checks++;
      if (grants !== 4'd0 || granted !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_hold got=%b/%b exp=0000/0", grants, granted);
      end
      rst = 1'b0;
      requests = 4'b0000;
      tick();
   endtask

   task automatic test_random;
      int   bad;
      logic prev_tout;
      requests = 4'b0000;
      enable   = 1'b1;
      do_reset();
      bad       = 0;
      prev_tout = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) requests = 4'($urandom_range(0, 15));
         enable = ($urandom_range(0, 4) != 0);
         rst    = ($urandom_range(0, 99) == 0);
         tick();
         n_checks++;
         if (grants !== m_grants || grant_id !== m_id || granted !== (m_grants != 4'd0) ||
             timeout !== m_tout || timeout_id !== m_tout_id || !$onehot0(grants) ||
             (prev_tout && timeout)) begin
            n_fail++;
            if (bad < 5) $display("FAIL random[%0d] got=%b/%0d/%b/%0d exp=%b/%0d/%b/%0d", i,
                                  grants, grant_id, timeout, timeout_id, m_grants, m_id, m_tout, m_tout_id);
            bad++;
         end
         prev_tout = timeout;
      end
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      requests = 4'b0000;
      test_reset();
      test_rotation();
      test_wrap_skip();
      test_watchdog();
      test_release_vs_timeout();
      test_enable_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
